sha256_round_ctrl: RTL and testbench

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

---
 rtl/sha256_round_ctrl.sv | 96 +++++++++
 tb/tb_sha256_round_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression round sequencer: INIT -> ROUNDS x ROUND -> FINAL -> DONE.
// Optional cancel input enabled by defining SHA_CTRL_ABORT_EN.
module sha256_round_ctrl #(
   parameter int ROUNDS     = 64,
   parameter int CNT_W      = 6,
   parameter int LOAD_WORDS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             done_ack,
`ifdef SHA_CTRL_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             hash_init,
   output logic             round_en,
   output logic [CNT_W-1:0] round_idx,
   output logic             w_load,
   output logic             h_add,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start) state_nxt = S_INIT;
         end
         S_INIT: begin
            cnt_nxt   = '0;
            state_nxt = S_ROUND;
         end
         S_ROUND: begin
            if (cnt == LAST_IDX) begin
               cnt_nxt   = '0;
               state_nxt = S_FINAL;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_FINAL: state_nxt = S_DONE;
         S_DONE: begin
            if (done_ack) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
`ifdef SHA_CTRL_ABORT_EN
      // abort wins over everything but rst, including a start seen in IDLE
      if (abort) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
      end
`endif
   end

   // outputs decode registered state only, so start/done_ack never reach them combinationally
   always_comb begin
      busy      = (state != S_IDLE);
      hash_init = (state == S_INIT);
      round_en  = (state == S_ROUND);
      round_idx = round_en ? cnt : '0;
      w_load    = round_en && (int'(cnt) < LOAD_WORDS);
      h_add     = (state == S_FINAL);
      done      = (state == S_DONE);
   end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Randomized bench for sha256_round_ctrl: a default instance and a ROUNDS=8 instance
// share stimulus and are compared each cycle against a cycles-since-start reference model.
module tb_sha256_round_ctrl;

   logic clk = 1'b0;
   logic rst, start, done_ack, abort;
   always #5 clk = ~clk;

   logic       busy0, hash_init0, round_en0, w_load0, h_add0, done0;
   logic [5:0] round_idx0;
   logic       busy1, hash_init1, round_en1, w_load1, h_add1, done1;
   logic [2:0] round_idx1;

   sha256_round_ctrl u_dut0 (
      .clk(clk), .rst(rst), .start(start), .done_ack(done_ack),
`ifdef SHA_CTRL_ABORT_EN
      .abort(abort),
`endif
      .busy(busy0), .hash_init(hash_init0), .round_en(round_en0), .round_idx(round_idx0),
      .w_load(w_load0), .h_add(h_add0), .done(done0)
   );

   sha256_round_ctrl #(.ROUNDS(8), .CNT_W(3), .LOAD_WORDS(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .done_ack(done_ack),
`ifdef SHA_CTRL_ABORT_EN
      .abort(abort),
`endif
      .busy(busy1), .hash_init(hash_init1), .round_en(round_en1), .round_idx(round_idx1),
      .w_load(w_load1), .h_add(h_add1), .done(done1)
   );

   logic [11:0] act0, act1;
   assign act0 = {busy0, hash_init0, round_en0, h_add0, done0, w_load0, round_idx0};
   assign act1 = {busy1, hash_init1, round_en1, h_add1, done1, w_load1, 3'b000, round_idx1};

   int checks = 0;
   int errors = 0;

   // model: a block is "on" from the accepted start; age counts cycles since acceptance
   bit m_on[2];
   int m_age[2];
   int rr[2] = '{64, 8};
   int ll[2] = '{16, 4};

   function automatic logic [11:0] expv(int k);
      logic re;
      int   idx;
      re  = m_on[k] && m_age[k] >= 2 && m_age[k] <= rr[k] + 1;
      idx = re ? m_age[k] - 2 : 0;
      return {m_on[k], m_on[k] && m_age[k] == 1, re, m_on[k] && m_age[k] == rr[k] + 2,
              m_on[k] && m_age[k] == rr[k] + 3, re && idx < ll[k], 6'(idx)};
   endfunction

   task automatic step(input logic s, input logic a, input logic r, input logic ab);
      start = s; done_ack = a; rst = r; abort = ab;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (r) m_on[k] = 0;
`ifdef SHA_CTRL_ABORT_EN
         else if (ab) m_on[k] = 0;
`endif
         else if (!m_on[k]) begin
            if (s) begin m_on[k] = 1; m_age[k] = 1; end
         end else if (m_age[k] == rr[k] + 3) begin
            if (a) m_on[k] = 0;
         end else m_age[k]++;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         checks += 2;
         if (act0 !== 12'h000) begin errors++; $display("FAIL reset0 got=%h exp=000", act0); end
         if (act1 !== 12'h000) begin errors++; $display("FAIL reset1 got=%h exp=000", act1); end
      end
   endtask

   task automatic test_basic_sequence();
      int n, hi_at, d0_at, d1_at, wl0, wl1, hi_cnt;
      hi_at = -1; d0_at = -1; d1_at = -1; wl0 = 0; wl1 = 0; hi_cnt = 0;
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n = 1;
      if (hash_init0) begin hi_at = 1; hi_cnt++; end
      // run until done0, then hold 20 cycles with stray starts
      while (n < 100 && !(d0_at > 0 && n >= d0_at + 20)) begin
         checks += 2;
         if (act0 !== expv(0)) begin errors++; $display("FAIL seq0 n=%0d got=%h exp=%h", n, act0, expv(0)); end
         if (act1 !== expv(1)) begin errors++; $display("FAIL seq1 n=%0d got=%h exp=%h", n, act1, expv(1)); end
         if (w_load0) wl0++;
         if (w_load1) wl1++;
         if (done0 && d0_at < 0) d0_at = n;
         if (done1 && d1_at < 0) d1_at = n;
         step(($urandom % 3) == 0, 1'b0, 1'b0, 1'b0);
         n++;
         if (hash_init0) begin hi_cnt++; if (hi_at < 0) hi_at = n; end
      end
      checks += 6;
      if (hi_at !== 1)  begin errors++; $display("FAIL hinit_lat got=%0d exp=1", hi_at); end
      if (d0_at !== 67) begin errors++; $display("FAIL done0_lat got=%0d exp=67", d0_at); end
      if (d1_at !== 11) begin errors++; $display("FAIL done1_lat got=%0d exp=11", d1_at); end
      if (wl0 !== 16)   begin errors++; $display("FAIL wload0_cnt got=%0d exp=16", wl0); end
      if (wl1 !== 4)    begin errors++; $display("FAIL wload1_cnt got=%0d exp=4", wl1); end
      if (hi_cnt !== 1) begin errors++; $display("FAIL hinit_cnt got=%0d exp=1", hi_cnt); end
      // ack together with start: block ends, start dropped
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks += 2;
      if ({busy0, done0} !== 2'b00) begin errors++; $display("FAIL ack_release got=%b exp=00", {busy0, done0}); end
      if (act1 !== expv(1)) begin errors++; $display("FAIL ack1 got=%h exp=%h", act1, expv(1)); end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (act0 !== 12'h000) begin errors++; $display("FAIL start_dropped got=%h exp=000", act0); end
   endtask

   task automatic test_mid_reset();
      int n, re_cnt;
      n = 0; re_cnt = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      while (!(round_en0 && round_idx0 == 6'd30) && n < 100) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         n++;
      end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL reach_idx30 timeout got=%0d exp<100", n); end
      step(1'b0, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (act0 !== 12'h000) begin errors++; $display("FAIL midrst0 got=%h exp=000", act0); end
      if (act1 !== 12'h000) begin errors++; $display("FAIL midrst1 got=%h exp=000", act1); end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 70; i++) begin
         checks++;
         if (act0 !== expv(0)) begin errors++; $display("FAIL rerun0 i=%0d got=%h exp=%h", i, act0, expv(0)); end
         if (round_en0) begin
            checks++;
            if (round_idx0 !== 6'(re_cnt)) begin errors++; $display("FAIL rerun_idx got=%0d exp=%0d", round_idx0, re_cnt); end
            re_cnt++;
         end
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      checks++;
      if (re_cnt !== 64) begin errors++; $display("FAIL rerun_rounds got=%0d exp=64", re_cnt); end
      step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic ab;
      for (int i = 0; i < 3000; i++) begin
         ab = 1'b0;
`ifdef SHA_CTRL_ABORT_EN
         ab = ($urandom % 60) == 0;
`endif
         step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 300) == 0, ab);
         checks += 3;
         if (act0 !== expv(0)) begin errors++; $display("FAIL rand0 i=%0d got=%h exp=%h", i, act0, expv(0)); end
         if (act1 !== expv(1)) begin errors++; $display("FAIL rand1 i=%0d got=%h exp=%h", i, act1, expv(1)); end
         if ($countones({hash_init0, round_en0, h_add0, done0}) > 1 ||
             $countones({hash_init1, round_en1, h_add1, done1}) > 1) begin
            errors++; $display("FAIL excl i=%0d got0=%h got1=%h exp=onehot0", i, act0, act1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int last0, last1, n0;
      last0 = -1; last1 = -1; n0 = 0;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4 * 68 + 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         checks += 3;
         if (act0 !== expv(0)) begin errors++; $display("FAIL b2b0 i=%0d got=%h exp=%h", i, act0, expv(0)); end
         if (act1 !== expv(1)) begin errors++; $display("FAIL b2b1 i=%0d got=%h exp=%h", i, act1, expv(1)); end
         if ($countones({hash_init0, round_en0, h_add0, done0}) > 1) begin
            errors++; $display("FAIL b2b_excl i=%0d got=%h exp=onehot0", i, act0);
         end
         if (hash_init0) begin
            if (last0 >= 0) begin
               checks++;
               if (i - last0 !== 68) begin errors++; $display("FAIL period0 got=%0d exp=68", i - last0); end
            end
            last0 = i; n0++;
         end
         if (hash_init1) begin
            if (last1 >= 0) begin
               checks++;
               if (i - last1 !== 12) begin errors++; $display("FAIL period1 got=%0d exp=12", i - last1); end
            end
            last1 = i;
         end
      end
      checks++;
      if (n0 < 4) begin errors++; $display("FAIL b2b_blocks got=%0d exp>=4", n0); end
      step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

`ifdef SHA_CTRL_ABORT_EN
   task automatic test_abort();
      int n, bad;
      n = 0; bad = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      while (!(round_en0 && round_idx0 == 6'd5) && n < 20) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         n++;
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (act0 !== 12'h000) begin errors++; $display("FAIL abort_idle got=%h exp=000", act0); end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (hash_init0 !== 1'b1) begin errors++; $display("FAIL abort_restart got=%b exp=1", hash_init0); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_start_supp got=%b exp=0", busy0); end
      for (int i = 0; i < 80; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         if (h_add0 || done0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", bad); end
   endtask
`endif

   initial begin
      m_on = '{0, 0};
      m_age = '{0, 0};
      test_reset();
      test_basic_sequence();
      test_mid_reset();
`ifdef SHA_CTRL_ABORT_EN
      test_abort();
`endif
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
